// File: rtl/reorder_buffer.sv
// Circular reorder buffer for the Tomasulo core. Hands out tags at issue,
// captures results from two CDB ports, commits one finished entry per cycle
// in program order, and resolves operand tags for the issue logic.
// Pointer wrap relies on DEPTH being a power of two.
module reorder_buffer #(
  parameter int unsigned        DEPTH       = 16,
  parameter int unsigned        TAGW        = 6,
  parameter logic [TAGW-1:0]    INVALID_TAG = 6'b010000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            alloc_valid,
  input  logic [4:0]      alloc_dest,
  output logic [TAGW-1:0] alloc_tag,
  output logic            full,
  output logic            empty,
  input  logic            cdb_valid,
  input  logic [TAGW-1:0] cdb_tag,
  input  logic [31:0]     cdb_data,
  input  logic            cdb2_valid,
  input  logic [TAGW-1:0] cdb2_tag,
  input  logic [31:0]     cdb2_data,
  input  logic [TAGW-1:0] lookup_tag_a,
  input  logic [TAGW-1:0] lookup_tag_b,
  output logic            lookup_ready_a,
  output logic            lookup_ready_b,
  output logic [31:0]     lookup_value_a,
  output logic [31:0]     lookup_value_b,
  output logic            commit_valid,
  output logic [4:0]      commit_reg,
  output logic [31:0]     commit_data,
  output logic [TAGW-1:0] commit_tag
);

  localparam int unsigned     PTRW      = $clog2(DEPTH);
  localparam logic [TAGW-1:0] DEPTH_TAG = TAGW'(DEPTH);
  localparam logic [PTRW:0]   DEPTH_CNT = (PTRW + 1)'(DEPTH);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] done;
  logic [4:0]       dest  [DEPTH];
  logic [31:0]      value [DEPTH];
  logic [PTRW-1:0]  head;
  logic [PTRW-1:0]  tail;
  logic [PTRW:0]    count;

  logic            alloc_ok;
  logic            commit_ok;
  logic            cdb_hit;
  logic            cdb2_hit;
  logic [PTRW-1:0] cdb_idx;
  logic [PTRW-1:0] cdb2_idx;
  logic [PTRW-1:0] idx_a;
  logic [PTRW-1:0] idx_b;

  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign alloc_tag = TAGW'(tail);

  // full is taken from the pre-edge count, so a full buffer never allocates
  assign alloc_ok  = alloc_valid && !full;
  assign commit_ok = busy[head] && done[head];

  assign cdb_idx  = cdb_tag[PTRW-1:0];
  assign cdb2_idx = cdb2_tag[PTRW-1:0];
  assign cdb_hit  = cdb_valid && (cdb_tag < DEPTH_TAG) && busy[cdb_idx] && !done[cdb_idx];
  assign cdb2_hit = cdb2_valid && (cdb2_tag < DEPTH_TAG) && busy[cdb2_idx] && !done[cdb2_idx];

  // Entry state, pointers, occupancy and the registered commit port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy         <= '0;
      done         <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_reg   <= '0;
      commit_data  <= '0;
      commit_tag   <= INVALID_TAG;
      for (int i = 0; i < DEPTH; i++) begin
        dest[i]  <= '0;
        value[i] <= '0;
      end
    end else if (flush) begin
      // Squash wins over every same-cycle alloc, capture and commit
      busy         <= '0;
      done         <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
    end else begin
      commit_valid <= commit_ok;
      if (commit_ok) begin
        commit_reg  <= dest[head];
        commit_data <= value[head];
        commit_tag  <= TAGW'(head);
        busy[head]  <= 1'b0;
        done[head]  <= 1'b0;
        head        <= head + 1'b1;
      end
      if (alloc_ok) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        dest[tail] <= alloc_dest;
        tail       <= tail + 1'b1;
      end
      // Port 1 is written last so it wins when both ports hit one entry
      if (cdb2_hit) begin
        value[cdb2_idx] <= cdb2_data;
        done[cdb2_idx]  <= 1'b1;
      end
      if (cdb_hit) begin
        value[cdb_idx] <= cdb_data;
        done[cdb_idx]  <= 1'b1;
      end
      case ({alloc_ok, commit_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign idx_a = lookup_tag_a[PTRW-1:0];
  assign idx_b = lookup_tag_b[PTRW-1:0];

  // Operand lookup A: stored value first, then same-cycle CDB forwarding
  always_comb begin
    lookup_ready_a = 1'b0;
    lookup_value_a = '0;
    if ((lookup_tag_a < DEPTH_TAG) && busy[idx_a]) begin
      if (done[idx_a]) begin
        lookup_ready_a = 1'b1;
        lookup_value_a = value[idx_a];
      end else if (cdb_valid && (cdb_tag == lookup_tag_a)) begin
        lookup_ready_a = 1'b1;
        lookup_value_a = cdb_data;
      end else if (cdb2_valid && (cdb2_tag == lookup_tag_a)) begin
        lookup_ready_a = 1'b1;
        lookup_value_a = cdb2_data;
      end
    end
  end

  // Operand lookup B: same resolution order as port A
  always_comb begin
    lookup_ready_b = 1'b0;
    lookup_value_b = '0;
    if ((lookup_tag_b < DEPTH_TAG) && busy[idx_b]) begin
      if (done[idx_b]) begin
        lookup_ready_b = 1'b1;
        lookup_value_b = value[idx_b];
      end else if (cdb_valid && (cdb_tag == lookup_tag_b)) begin
        lookup_ready_b = 1'b1;
        lookup_value_b = cdb_data;
      end else if (cdb2_valid && (cdb2_tag == lookup_tag_b)) begin
        lookup_ready_b = 1'b1;
        lookup_value_b = cdb2_data;
      end
    end
  end

endmodule
